// File: rtl/mac_pkg.sv
// Shared types and default widths for the multiply-accumulate datapath.
// The multiplier, this accumulator and later MAC stages all import it.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int MAC_PROD_W = 8;
    localparam int MAC_ACC_W  = 12;
    localparam int MAC_LEN_W  = 4;

    localparam logic [MAC_ACC_W-1:0] ACC_MAX = {MAC_ACC_W{1'b1}};

endpackage

// File: rtl/sat_adder.sv
// Unsigned add of an A_W-bit accumulator and a zero-extended B_W-bit operand.
// The result clamps to all ones when the sum does not fit in A_W bits.
module sat_adder #(
    parameter int A_W = 12,
    parameter int B_W = 8
) (
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    output logic [A_W-1:0] sum,
    output logic           ovf
);

    logic [A_W:0] wide;

    always_comb begin
        wide = {1'b0, a} + (A_W+1)'(b);
        ovf  = wide[A_W];
        sum  = wide[A_W] ? {A_W{1'b1}} : wide[A_W-1:0];
    end

endmodule

// File: rtl/product_accumulator.sv
// Sums a programmed number of multiplier products into a saturating accumulator
// and hands the result out on a registered valid/ready port.
module product_accumulator
    import mac_pkg::*;
#(
    parameter int PROD_W = MAC_PROD_W,
    parameter int ACC_W  = MAC_ACC_W,
    parameter int LEN_W  = MAC_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_overflow,
    output logic              busy
);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic [LEN_W-1:0] remaining;

    logic [ACC_W-1:0] acc_nxt;
    logic             add_ovf;
    logic             beat;

    sat_adder #(
        .A_W (ACC_W),
        .B_W (PROD_W)
    ) u_sat_adder (
        .a   (acc),
        .b   (in_product),
        .sum (acc_nxt),
        .ovf (add_ovf)
    );

    assign in_ready = (state == ACCUM);
    assign busy     = (state != IDLE);
    assign beat     = in_valid && in_ready;

    // Result registers are loaded on the transition into DONE, so out_valid
    // rises the cycle after the final beat and stays stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            acc          <= '0;
            ovf          <= 1'b0;
            remaining    <= '0;
            out_valid    <= 1'b0;
            out_sum      <= '0;
            out_overflow <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc <= '0;
                        ovf <= 1'b0;
                        if (len == '0) begin
                            state        <= DONE;
                            out_valid    <= 1'b1;
                            out_sum      <= '0;
                            out_overflow <= 1'b0;
                        end else begin
                            remaining <= len;
                            state     <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc       <= acc_nxt;
                        ovf       <= ovf | add_ovf;
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state        <= DONE;
                            out_valid    <= 1'b1;
                            out_sum      <= acc_nxt;
                            out_overflow <= ovf | add_ovf;
                        end
                    end
                end
                DONE: begin
                    // start is deliberately not looked at here; a new job
                    // needs a fresh request once back in IDLE.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
